ahb_master: RTL and testbench

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_master.sv | 127 ++++++++++++
 tb/tb_ahb_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the master and slave blocks.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/ahb_master.sv
// AHB-Lite master: address stage (A) and data stage (D), single transfers only.
// A two-cycle ERROR response parks the pending address phase and re-issues it afterwards.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_htrans,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [3:0]            o_hprot,
  output logic                  o_hmastlock,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic                  i_hready,
  input  logic                  i_hresp,
  input  logic [DATA_WIDTH-1:0] i_hrdata
);

  logic                  r_a_vld;
  logic                  r_a_write;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [2:0]            r_a_size;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  logic                  r_d_vld;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic                  r_err_hold;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_accept;
  logic w_a_adv;
  logic w_d_done;

  // err_hold blocks the A->D move during the second ERROR cycle
  assign w_a_adv  = i_hready && r_a_vld && !r_err_hold;
  assign w_d_done = i_hready && r_d_vld;
  assign o_ready  = !r_a_vld || (i_hready && !r_err_hold);
  assign w_accept = i_valid && o_ready;

  assign o_htrans    = (r_a_vld && !r_err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign o_haddr     = r_a_addr;
  assign o_hwrite    = r_a_write;
  assign o_hsize     = r_a_size;
  assign o_hburst    = HBURST_SINGLE;
  assign o_hprot     = HPROT_DATA_PRIV;
  assign o_hmastlock = 1'b0;
  assign o_hwdata    = r_hwdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rd_data   = r_rd_data;

  // Address fields only change on acceptance, so the bus keeps its last address when idle
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_a_vld   <= 1'b0;
      r_a_write <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= '0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_vld   <= 1'b1;
      r_a_write <= i_rd0_wr1;
      r_a_addr  <= i_addr;
      r_a_size  <= i_size;
      r_a_wdata <= i_wr_data;
    end else if (w_a_adv) begin
      r_a_vld   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_d_vld   <= 1'b0;
      r_d_write <= 1'b0;
      r_hwdata  <= '0;
    end else begin
      if (i_hready) r_d_vld <= r_a_vld && !r_err_hold;
      if (w_a_adv) begin
        r_d_write <= r_a_write;
        if (r_a_write) r_hwdata <= r_a_wdata;
      end
    end
  end

  // First ERROR cycle (HREADY low) arms the hold; the completing second cycle releases it
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_err_hold <= 1'b0;
    end else if (r_d_vld && i_hresp && !i_hready) begin
      r_err_hold <= 1'b1;
    end else if (i_hready) begin
      r_err_hold <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_data   <= '0;
    end else if (w_d_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= i_hresp;
      r_rd_data   <= r_d_write ? '0 : i_hrdata;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed vector table, corner-case sequences and a random run
// against a transaction-level model (request queue + AHB slave plan + response scoreboard).
module tb_ahb_master;
  import ahb_pkg::*;

  logic        clk;
  logic        rstn;
  logic        valid, rd0_wr1;
  logic [31:0] addr, wdata;
  logic [2:0]  size;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        o_ready, o_rsp_valid, o_rsp_err, o_hwrite, o_hmastlock;
  logic [31:0] o_rd_data, o_haddr, o_hwdata;
  logic [1:0]  o_htrans;
  logic [2:0]  o_hsize, o_hburst;
  logic [3:0]  o_hprot;

  ahb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk_ahb(clk), .i_rstn_ahb(rstn),
    .i_valid(valid), .o_ready(o_ready), .i_rd0_wr1(rd0_wr1), .i_addr(addr),
    .i_size(size), .i_wr_data(wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rd_data(o_rd_data),
    .o_htrans(o_htrans), .o_haddr(o_haddr), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
    .o_hburst(o_hburst), .o_hprot(o_hprot), .o_hmastlock(o_hmastlock), .o_hwdata(o_hwdata),
    .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; int acc; } req_t;
  typedef struct { int waits; bit err; logic [31:0] rdata; } plan_t;
  typedef struct { bit err; logic [31:0] data; int lat; } rsp_t;
  typedef struct {
    bit wr; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata;
    int waits; bit err; logic [31:0] rdata;
    bit exp_err; logic [31:0] exp_data; int exp_lat;
  } vec_t;

  int checks = 0, failures = 0, cyc = 0;
  req_t  req_q[$], acc_q[$];
  plan_t plan_q[$];
  rsp_t  rsp_log[$];
  req_t  dp_req;
  plan_t dp_plan;
  rsp_t  rsp_exp;
  bit    dp_act = 0, rsp_due = 0, noise = 0;
  int    dp_cnt = 0;
  logic [31:0] last_addr = '0;
  int ns_run = 0, ns_max = 0, rdy_low = 0, idle_hold = 0;
  vec_t tv[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic plan_t rnd_plan();
    plan_t p;
    p.waits = int'($urandom_range(2));
    p.err   = ($urandom_range(7) == 0);
    p.rdata = $urandom();
    return p;
  endfunction

  task automatic model_clear();
    req_q.delete(); acc_q.delete(); plan_q.delete();
    dp_act = 0; rsp_due = 0; last_addr = '0;
  endtask

  // One bus cycle: check outputs against the model, play the slave, advance the model
  task automatic step();
    bit in_err2, fin, exp_rdy;
    logic [1:0] exp_trans;
    @(negedge clk);
    cyc++;
    if (rsp_due) begin
      chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
      chk("rsp_err", 64'(o_rsp_err), 64'(rsp_exp.err));
      chk("rsp_data", 64'(o_rd_data), 64'(rsp_exp.data));
      rsp_log.push_back('{err: o_rsp_err, data: o_rd_data, lat: cyc - rsp_exp.lat});
    end else begin
      chk("rsp_idle", 64'(o_rsp_valid), 64'd0);
    end
    rsp_due = 0;
    in_err2 = 0; fin = 0;
    if (dp_act) begin
      if (dp_cnt < dp_plan.waits) begin hready = 0; hresp = 0; end
      else if (dp_plan.err && dp_cnt == dp_plan.waits) begin hready = 0; hresp = 1; end
      else begin hready = 1; hresp = dp_plan.err; in_err2 = dp_plan.err; fin = 1; end
      hrdata = fin ? dp_plan.rdata : $urandom();
    end else begin
      hready = noise ? ($urandom_range(3) != 0) : 1'b1;
      hresp  = noise ? 1'($urandom_range(1)) : 1'b0;
      hrdata = $urandom();
    end
    if (req_q.size() > 0 && (!noise || $urandom_range(2) != 0)) begin
      valid = 1; rd0_wr1 = req_q[0].wr; addr = req_q[0].addr;
      size = req_q[0].size; wdata = req_q[0].wdata;
    end else begin
      valid = 0; rd0_wr1 = 1'($urandom_range(1)); addr = $urandom();
      size = 3'($urandom_range(7)); wdata = $urandom();
    end
    #1;
    exp_rdy = (acc_q.size() == 0) || (hready && !in_err2);
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    exp_trans = (acc_q.size() > 0 && !in_err2) ? HTRANS_NONSEQ : HTRANS_IDLE;
    chk("htrans", 64'(o_htrans), 64'(exp_trans));
    if (acc_q.size() > 0) begin
      chk("haddr", 64'(o_haddr), 64'(acc_q[0].addr));
      chk("hwrite", 64'(o_hwrite), 64'(acc_q[0].wr));
      chk("hsize", 64'(o_hsize), 64'(acc_q[0].size));
    end else begin
      chk("haddr_hold", 64'(o_haddr), 64'(last_addr));
    end
    chk("const_ctl", 64'({o_hburst, o_hprot, o_hmastlock}), 64'({3'b000, 4'b0011, 1'b0}));
    if (dp_act && dp_req.wr) chk("hwdata", 64'(o_hwdata), 64'(dp_req.wdata));
    if (o_htrans == HTRANS_NONSEQ) ns_run++; else ns_run = 0;
    if (ns_run > ns_max) ns_max = ns_run;
    if (!o_ready) rdy_low++;
    if (in_err2 && acc_q.size() > 0 && o_htrans == HTRANS_IDLE) idle_hold++;
    if (dp_act && hready) begin
      rsp_due = 1;
      rsp_exp = '{err: dp_plan.err, data: dp_req.wr ? 32'h0 : dp_plan.rdata, lat: dp_req.acc};
      dp_act = 0;
    end else if (dp_act) begin
      dp_cnt++;
    end
    if (hready && !in_err2 && acc_q.size() > 0) begin
      dp_req = acc_q.pop_front();
      dp_act = 1; dp_cnt = 0;
      dp_plan = (plan_q.size() > 0) ? plan_q.pop_front() : rnd_plan();
    end
    if (valid && o_ready && req_q.size() > 0) begin
      req_t r;
      r = req_q.pop_front();
      r.acc = cyc;
      acc_q.push_back(r);
      last_addr = r.addr;
    end
  endtask

  task automatic run_until(input int target, input int budget, input string what);
    int k = 0;
    while (rsp_log.size() < target && k < budget) begin step(); k++; end
    chk({what, "_rsp_count"}, 64'(rsp_log.size()), 64'(target));
    step();
  endtask

  task automatic do_reset();
    rstn = 0; valid = 0; rd0_wr1 = 0; addr = '0; size = '0; wdata = '0;
    hready = 1; hresp = 0; hrdata = '0;
    repeat (2) @(negedge clk);
    model_clear();
    #1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_htrans", 64'(o_htrans), 64'(HTRANS_IDLE));
    chk("rst_addr_ctl", 64'({o_haddr, o_hwrite, o_hsize}), 64'd0);
    chk("rst_hwdata", 64'(o_hwdata), 64'd0);
    chk("rst_rsp", 64'({o_rsp_valid, o_rsp_err, o_rd_data}), 64'd0);
    @(negedge clk) rstn = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1'b1, 32'h1000, HSIZE_WORD, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 32'h0,        3};
    tv[1] = '{1'b0, 32'h2000, HSIZE_WORD, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 3};
    tv[2] = '{1'b0, 32'h0020, HSIZE_WORD, 32'h0,        2, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 5};
    tv[3] = '{1'b1, 32'h0030, HSIZE_BYTE, 32'h000000A5, 1, 1'b0, 32'h0,        1'b0, 32'h0,        4};
    tv[4] = '{1'b0, 32'h0050, HSIZE_HALF, 32'h0,        0, 1'b1, 32'h00000055, 1'b1, 32'h00000055, 4};
    tv[5] = '{1'b1, 32'h0040, HSIZE_WORD, 32'h11112222, 1, 1'b1, 32'h0,        1'b1, 32'h0,        5};
    do_reset();

    foreach (tv[i]) begin
      rsp_log.delete();
      plan_q.push_back('{waits: tv[i].waits, err: tv[i].err, rdata: tv[i].rdata});
      req_q.push_back('{wr: tv[i].wr, addr: tv[i].addr, size: tv[i].size, wdata: tv[i].wdata, acc: 0});
      run_until(1, 20, "vec");
      if (rsp_log.size() > 0) begin
        chk("vec_err", 64'(rsp_log[0].err), 64'(tv[i].exp_err));
        chk("vec_data", 64'(rsp_log[0].data), 64'(tv[i].exp_data));
        chk("vec_latency", 64'(rsp_log[0].lat), 64'(tv[i].exp_lat));
      end
    end

    // Back-to-back reads with valid held
    rsp_log.delete(); ns_run = 0; ns_max = 0;
    for (int i = 0; i < 3; i++) begin
      req_q.push_back('{wr: 0, addr: 32'(4 * i), size: HSIZE_WORD, wdata: 0, acc: 0});
      plan_q.push_back('{waits: 0, err: 0, rdata: 32'h111 * 32'(i + 1)});
    end
    run_until(3, 30, "b2b");
    chk("b2b_nonseq_run", 64'(ns_max), 64'd3);
    foreach (rsp_log[i]) begin
      chk("b2b_data", 64'(rsp_log[i].data), 64'(32'h111 * 32'(i + 1)));
      chk("b2b_latency", 64'(rsp_log[i].lat), 64'd3);
    end

    // Wait states with a second request stuck in the address stage
    rsp_log.delete(); rdy_low = 0;
    req_q.push_back('{wr: 0, addr: 32'h20, size: HSIZE_WORD, wdata: 0, acc: 0});
    req_q.push_back('{wr: 0, addr: 32'h24, size: HSIZE_WORD, wdata: 0, acc: 0});
    plan_q.push_back('{waits: 2, err: 0, rdata: 32'hA0A0A0A0});
    plan_q.push_back('{waits: 0, err: 0, rdata: 32'hB0B0B0B0});
    run_until(2, 30, "wait");
    chk("wait_ready_low", 64'(rdy_low), 64'd2);
    if (rsp_log.size() == 2) begin
      chk("wait_latency", 64'(rsp_log[0].lat), 64'd5);
      chk("wait_data2", 64'(rsp_log[1].data), 64'hB0B0B0B0);
    end

    // Error on 0x40 while 0x44 waits in the address stage
    rsp_log.delete(); idle_hold = 0;
    req_q.push_back('{wr: 1, addr: 32'h40, size: HSIZE_WORD, wdata: 32'h40404040, acc: 0});
    req_q.push_back('{wr: 1, addr: 32'h44, size: HSIZE_WORD, wdata: 32'h44444444, acc: 0});
    plan_q.push_back('{waits: 0, err: 1, rdata: 0});
    plan_q.push_back('{waits: 0, err: 0, rdata: 0});
    run_until(2, 30, "err");
    chk("err_idle_cycles", 64'(idle_hold), 64'd1);
    if (rsp_log.size() == 2) begin
      chk("err_first", 64'(rsp_log[0].err), 64'd1);
      chk("err_second", 64'(rsp_log[1].err), 64'd0);
    end

    // Random traffic with random waits, errors and idle-bus noise
    rsp_log.delete(); noise = 1;
    for (int i = 0; i < 300; i++)
      req_q.push_back('{wr: 1'($urandom_range(1)), addr: $urandom(),
                        size: 3'($urandom_range(2)), wdata: $urandom(), acc: 0});
    run_until(300, 8000, "rand");
    noise = 0;
    repeat (3) step();

    // Reset asserted during a data phase
    req_q.push_back('{wr: 1, addr: 32'h80, size: HSIZE_WORD, wdata: 32'h80808080, acc: 0});
    plan_q.push_back('{waits: 3, err: 0, rdata: 0});
    for (int k = 0; k < 10 && !dp_act; k++) step();
    chk("mid_reset_in_dp", 64'(dp_act), 64'd1);
    step();
    #2 rstn = 0;
    #1;
    chk("mid_reset_htrans", 64'(o_htrans), 64'(HTRANS_IDLE));
    chk("mid_reset_rsp", 64'(o_rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    model_clear();
    valid = 0; hready = 1; hresp = 0;
    @(negedge clk) rstn = 1;
    #1;
    chk("post_reset_ready", 64'(o_ready), 64'd1);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
